// File: rtl/tone_meter_pkg.sv
// Shared types and helpers for the tone frequency meter.
package tone_meter_pkg;

   typedef enum logic {
      SETTLE = 1'b0,
      RUN    = 1'b1
   } state_t;

   function automatic int unsigned gate_cycles(input int unsigned clk_freq,
                                               input int unsigned gate_shift);
      return clk_freq >> gate_shift;
   endfunction

endpackage

// File: rtl/tone_meter_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, followed by a registered
// rising-edge detector (rise is high one cycle, three clocks after din rises).
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic meta_q, sync_q, prev_q, rise_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/tone_meter.sv
// Gated edge counter: counts synchronised rising edges of tone_in over a fixed
// window and publishes the scaled count (Hz) plus status flags once per window.
module tone_meter
   import tone_meter_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned GATE_SHIFT = 3,
   parameter int unsigned COUNT_W    = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tone_in,
   output logic [31:0] freq,
   output logic        valid,
   output logic        silent,
   output logic        overflow,
   output logic        changed
);

   localparam int unsigned GATE_CYCLES = gate_cycles(CLK_FREQ, GATE_SHIFT);
   localparam int unsigned GCNT_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GCNT_W-1:0]  GCNT_LAST = GCNT_W'(GATE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] ECNT_MAX  = '1;

   state_t              state_q, state_d;
   logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
   logic [COUNT_W-1:0]  ecnt_q, ecnt_d;
   logic                sat_q, sat_d;
   logic [31:0]         freq_q, freq_d;
   logic                valid_q, valid_d;
   logic                silent_q, silent_d;
   logic                overflow_q, overflow_d;
   logic                changed_q, changed_d;

   logic                rise;
   logic                terminal;
   logic                at_max;
   logic [COUNT_W-1:0]  total;
   logic [31:0]         freq_new;

   sync_edge u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (tone_in),
      .rise (rise)
   );

   assign terminal = (gcnt_q == GCNT_LAST);
   assign at_max   = (ecnt_q == ECNT_MAX);
   // An edge landing in the terminal cycle still belongs to the closing window.
   assign total    = (rise && !at_max) ? ecnt_q + 1'b1 : ecnt_q;
   assign freq_new = 32'(total) << GATE_SHIFT;

   always_comb begin
      state_d    = state_q;
      gcnt_d     = gcnt_q + 1'b1;
      ecnt_d     = ecnt_q;
      sat_d      = sat_q;
      freq_d     = freq_q;
      valid_d    = 1'b0;
      silent_d   = silent_q;
      overflow_d = overflow_q;
      changed_d  = 1'b0;

      if (terminal) begin
         gcnt_d  = '0;
         ecnt_d  = '0;
         sat_d   = 1'b0;
         state_d = RUN;
         if (state_q == RUN) begin
            freq_d     = freq_new;
            valid_d    = 1'b1;
            silent_d   = (total == '0);
            overflow_d = sat_q | (rise & at_max);
            changed_d  = (freq_new != freq_q);
         end
      end else if (rise) begin
         if (at_max) sat_d  = 1'b1;
         else        ecnt_d = ecnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= SETTLE;
         gcnt_q     <= '0;
         ecnt_q     <= '0;
         sat_q      <= 1'b0;
         freq_q     <= '0;
         valid_q    <= 1'b0;
         silent_q   <= 1'b1;
         overflow_q <= 1'b0;
         changed_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gcnt_q     <= gcnt_d;
         ecnt_q     <= ecnt_d;
         sat_q      <= sat_d;
         freq_q     <= freq_d;
         valid_q    <= valid_d;
         silent_q   <= silent_d;
         overflow_q <= overflow_d;
         changed_q  <= changed_d;
      end
   end

   assign freq     = freq_q;
   assign valid    = valid_q;
   assign silent   = silent_q;
   assign overflow = overflow_q;
   assign changed  = changed_q;

endmodule

// File: tb/tb_tone_meter.sv
// Randomised bench for tone_meter: a full-width and a 4-bit-counter instance
// share one tone input and are checked against a per-window edge-count model.
module tb_tone_meter;

   localparam int unsigned CLK_FREQ   = 8000;
   localparam int unsigned GATE_SHIFT = 3;
   localparam int          G          = 1000;
   localparam int          MAXC       = 40000;
   localparam int          SIL = 0, SQ = 1, NOISE = 2, PULSE = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tone_in = 1'b0;
   logic [31:0] freq, freq_s;
   logic        valid, silent, overflow, changed;
   logic        valid_s, silent_s, overflow_s, changed_s;

   tone_meter #(.CLK_FREQ(CLK_FREQ), .GATE_SHIFT(GATE_SHIFT), .COUNT_W(24)) dut (
      .clk(clk), .rst(rst), .tone_in(tone_in), .freq(freq), .valid(valid),
      .silent(silent), .overflow(overflow), .changed(changed));

   tone_meter #(.CLK_FREQ(CLK_FREQ), .GATE_SHIFT(GATE_SHIFT), .COUNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .tone_in(tone_in), .freq(freq_s), .valid(valid_s),
      .silent(silent_s), .overflow(overflow_s), .changed(changed_s));

   always #5 clk = ~clk;

   bit          t [MAXC];
   int          n;
   int          n_checks, n_errors;
   int unsigned prev_f, prev_fs;
   int          mode, per, ofs, pa;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, n, obs, exp);
      end
   endtask

   function automatic bit tone_at(input int i);
      if (i < 0) return 1'b0;
      return t[i];
   endfunction

   // Rising edges of tone_in reach the counter three cycles late.
   function automatic int unsigned window_edges(input int k);
      int unsigned c;
      c = 0;
      for (int m = k * G; m < (k + 1) * G; m++)
         if (tone_at(m - 3) && !tone_at(m - 4)) c++;
      return c;
   endfunction

   task automatic check_cycle();
      bit          pub;
      int unsigned cnt, cs, f, fs;
      pub = (n >= 2 * G) && (n % G == 0);
      chk("valid", valid, 32'(pub));
      chk("valid_sat", valid_s, 32'(pub));
      if (pub) begin
         cnt = window_edges(n / G - 1);
         f   = cnt << GATE_SHIFT;
         cs  = (cnt > 15) ? 15 : cnt;
         fs  = cs << GATE_SHIFT;
         chk("freq", freq, f);
         chk("silent", silent, 32'(cnt == 0));
         chk("overflow", overflow, 32'(cnt > 32'h00FF_FFFF));
         chk("changed", changed, 32'(f != prev_f));
         chk("freq_sat", freq_s, fs);
         chk("silent_sat", silent_s, 32'(cnt == 0));
         chk("overflow_sat", overflow_s, 32'(cnt > 15));
         chk("changed_sat", changed_s, 32'(fs != prev_fs));
         prev_f  = f;
         prev_fs = fs;
      end else begin
         chk("freq_hold", freq, prev_f);
         chk("changed_idle", changed, 32'd0);
         chk("freq_hold_sat", freq_s, prev_fs);
         chk("changed_idle_sat", changed_s, 32'd0);
      end
   endtask

   task automatic drive();
      bit v;
      case (mode)
         SQ:      v = ((n + ofs) % per) < (per / 2);
         NOISE:   v = 1'($urandom_range(0, 1));
         PULSE:   v = (n >= pa) && (n < pa + 20);
         default: v = 1'b0;
      endcase
      if (n >= MAXC) begin
         $display("FAIL history_overflow at cycle %0d: got %0d expected %0d", n, n, MAXC);
         $fatal(1, "history buffer exhausted");
      end
      t[n]    = v;
      tone_in = v;
   endtask

   task automatic step();
      check_cycle();
      drive();
      n++;
      @(negedge clk);
   endtask

   task automatic run_to(input int target);
      while (n < target) step();
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      tone_in = 1'b0;
      #1;
      chk("rst_async_freq", freq, 32'd0);
      chk("rst_async_valid", valid, 32'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_freq", freq, 32'd0);
      chk("rst_silent", silent, 32'd1);
      chk("rst_valid", valid, 32'd0);
      chk("rst_overflow", overflow, 32'd0);
      chk("rst_changed", changed, 32'd0);
      chk("rst_freq_sat", freq_s, 32'd0);
      chk("rst_silent_sat", silent_s, 32'd1);
      rst     = 1'b0;
      n       = 0;
      prev_f  = 0;
      prev_fs = 0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      n        = 0;
      mode     = SIL;
      per      = 100;
      ofs      = 0;
      pa       = 0;
      @(negedge clk);
      do_reset();

      // steady 100-cycle tone, then silence
      mode = SQ; per = 100; ofs = 0;
      run_to(3001);
      mode = SIL;
      run_to(5001);

      // single edge in the terminal cycle of window 5, then just after window 7
      mode = PULSE; pa = 6 * G - 1 - 3;
      run_to(7001);
      pa = 8 * G - 3;
      run_to(9001);

      // reset mid-window
      mode = SQ; per = 100; ofs = 0;
      do_reset();
      run_to(2500);
      do_reset();
      run_to(2001);

      // saturation of the 4-bit counter, then recovery
      mode = SQ; per = 4; ofs = 0;
      run_to(3001);
      mode = SQ; per = 100;
      run_to(5001);

      // random segments
      repeat (12) begin
         mode = $urandom_range(0, 2);
         per  = $urandom_range(2, 300);
         ofs  = $urandom_range(0, 299);
         run_to(n + $urandom_range(300, 1700));
      end
      run_to((n / G + 2) * G + 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
